// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared widths, types and stage-1 record for fp_normalizer_pipe
package fp_norm_pkg;

    localparam int MANT_W    = 32;
    localparam int LZC_W     = 5;
    localparam int DEF_EXP_W = 8;
    localparam int DEF_TAG_W = 4;

    typedef logic [MANT_W-1:0] mant_t;
    typedef logic [LZC_W-1:0]  lzc_t;

    // Stage-1 record; exp/tag fields are sized for the default parameter widths
    typedef struct packed {
        mant_t                mant;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_TAG_W-1:0] tag;
        lzc_t                 z;
        logic                 v;
    } s1_t;

endpackage

// File: rtl/LZC_32_bit.sv
// rtl/LZC_32_bit.sv - 32-bit leading-zero counter, Z = count, V = input non-zero
module LZC_32_bit (
    input  logic [31:0] a,
    output logic [4:0]  Z,
    output logic        V
);

    // Scan upward so the highest set bit decides the count; Z is 0 when a==0
    always_comb begin
        Z = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                Z = 5'(31 - i);
            end
        end
        V = |a;
    end

endmodule

// File: rtl/fp_normalizer_pipe.sv
// rtl/fp_normalizer_pipe.sv - 2-stage mantissa normalizer; FP_NORM_DENORM_EN selects gradual underflow
module fp_normalizer_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_uf
);

    logic             r_s1_valid;
    s1_t              r_s1;
    logic             r_out_valid;
    logic [31:0]      r_out_mant;
    logic [EXP_W-1:0] r_out_exp;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_zero;
    logic             r_out_uf;

    lzc_t             w_z;
    logic             w_v;
    logic             w_s2_free;
    logic             w_in_ready;
    logic [EXP_W-1:0] w_z_ext;
    mant_t            w_mant;
    logic [EXP_W-1:0] w_exp;
    logic             w_zero;
    logic             w_uf;

    LZC_32_bit u_lzc (
        .a (in_mant),
        .Z (w_z),
        .V (w_v)
    );

    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_z_ext    = EXP_W'(r_s1.z);

`ifdef FP_NORM_DENORM_EN
    // Denormal shift stops one short of the exponent so the value lands at exponent 0
    lzc_t w_dn_shift;
    assign w_dn_shift = (r_s1.exp == '0) ? '0 : LZC_W'(r_s1.exp - 1'b1);
`endif

    // Stage-2 result: zero, normal, or underflow; compare precedes subtract so no wrap
    always_comb begin
        w_mant = '0;
        w_exp  = '0;
        w_zero = 1'b0;
        w_uf   = 1'b0;
        if (!r_s1.v) begin
            w_zero = 1'b1;
        end else if (r_s1.exp > w_z_ext) begin
            w_mant = r_s1.mant << r_s1.z;
            w_exp  = r_s1.exp - w_z_ext;
        end else begin
            w_uf = 1'b1;
`ifdef FP_NORM_DENORM_EN
            w_mant = r_s1.mant << w_dn_shift;
            w_zero = (w_mant == '0);
`else
            w_zero = 1'b1;
`endif
        end
    end

    // Stage 1: capture the beat and its leading-zero count whenever the slot frees up
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.mant <= in_mant;
                r_s1.exp  <= in_exp;
                r_s1.tag  <= in_tag;
                r_s1.z    <= w_z;
                r_s1.v    <= w_v;
            end
        end
    end

    // Stage 2: load a new result when free, otherwise hold or drain on out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_tag   <= '0;
            r_out_zero  <= 1'b0;
            r_out_uf    <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_mant <= w_mant;
                r_out_exp  <= w_exp;
                r_out_tag  <= r_s1.tag;
                r_out_zero <= w_zero;
                r_out_uf   <= w_uf;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_mant  = r_out_mant;
    assign out_exp   = r_out_exp;
    assign out_tag   = r_out_tag;
    assign out_zero  = r_out_zero;
    assign out_uf    = r_out_uf;

endmodule
